// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - Edge-triggered interrupt controller with fixed priority and a single-level request/service handshake.
// Pending and overflow flags are captured per source; the FSM hands one cause at a time to the core.
module irq_ctrl #(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic [N_SRC-1:0]   irq_mask,
    input  logic               ir_ack,
    input  logic               ir_eret,
    input  logic               ovf_clr,
    output logic               ir_out,
    output logic [CAUSE_W-1:0] ir_cause,
    output logic [N_SRC-1:0]   pending,
    output logic [N_SRC-1:0]   overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_sync [SYNC_STAGES];
    logic [N_SRC-1:0]   r_prev;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_overflow;
    logic               r_ir_out;
    logic [CAUSE_W-1:0] r_cause;

    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_clr;
    logic [CAUSE_W-1:0] w_winner;
    logic [CAUSE_W-1:0] w_cause_nxt;
    logic               w_ir_out_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_eligible = r_pending & irq_mask;

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cause_nxt  = r_cause;
        w_ir_out_nxt = r_ir_out;
        w_clr        = '0;
        case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt  = S_REQ;
                    w_cause_nxt  = w_winner;
                    w_ir_out_nxt = 1'b1;
                end
            end
            S_REQ: begin
                // Ack beats a same-cycle mask drop; a masked cause without ack withdraws the request.
                if (ir_ack) begin
                    w_state_nxt    = S_SERVICE;
                    w_ir_out_nxt   = 1'b0;
                    w_clr[r_cause] = 1'b1;
                end else if (!irq_mask[r_cause]) begin
                    w_state_nxt  = S_IDLE;
                    w_ir_out_nxt = 1'b0;
                end
            end
            S_SERVICE: begin
                w_ir_out_nxt = 1'b0;
                if (ir_eret) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_ir_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ir_out   <= 1'b0;
            r_cause    <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir_out   <= w_ir_out_nxt;
            r_cause    <= w_cause_nxt;
            // An edge landing on the bit being acked re-arms it instead of counting as lost.
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            r_overflow <= (ovf_clr ? '0 : r_overflow) | (w_edge & r_pending & ~w_clr);
        end
    end

    assign ir_out   = r_ir_out;
    assign ir_cause = r_cause;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - Directed scenarios plus randomized traffic against a behavioural model of irq_ctrl.
module tb_irq_ctrl;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq_src = '0;
    logic [N-1:0]  irq_mask = '0;
    logic          ir_ack = 1'b0;
    logic          ir_eret = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          ir_out;
    logic [CW-1:0] ir_cause;
    logic [N-1:0]  pending;
    logic [N-1:0]  overflow;

    int n_vec = 0;
    int n_err = 0;

    irq_ctrl #(.N_SRC(N), .SYNC_STAGES(SS), .CAUSE_W(CW)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .irq_mask(irq_mask),
        .ir_ack(ir_ack), .ir_eret(ir_eret), .ovf_clr(ovf_clr),
        .ir_out(ir_out), .ir_cause(ir_cause), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: history of raw samples (index k = sampled k edges ago), a phase number and flag vectors.
    logic [N-1:0]  m_hist [$];
    int            m_phase;   // 0 idle, 1 requesting, 2 in handler
    logic          m_out;
    int            m_cause;
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_ovf;

    task automatic model_clear();
        m_hist.delete();
        for (int k = 0; k < SS + 2; k++) m_hist.push_back('0);
        m_phase = 0;
        m_out   = 1'b0;
        m_cause = 0;
        m_pend  = '0;
        m_ovf   = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] edges, elig, clr;
        if (rst) begin
            model_clear();
            return;
        end
        m_hist.push_front(irq_src);
        void'(m_hist.pop_back());
        edges = m_hist[SS] & ~m_hist[SS+1];
        elig  = m_pend & irq_mask;
        clr   = '0;
        if (m_phase == 0) begin
            if (elig != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (elig[i]) begin
                        m_cause = i;
                        break;
                    end
                end
                m_phase = 1;
                m_out   = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (ir_ack) begin
                clr[m_cause] = 1'b1;
                m_phase = 2;
                m_out   = 1'b0;
            end else if (!irq_mask[m_cause]) begin
                m_phase = 0;
                m_out   = 1'b0;
            end
        end else if (ir_eret) begin
            m_phase = 0;
        end
        m_ovf  = (ovf_clr ? '0 : m_ovf) | (edges & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | edges;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; irq_src = '0; irq_mask = '0;
        ir_ack = 1'b0; ir_eret = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (ir_out !== 1'b0 || ir_cause !== 2'd0) begin
            n_err++; $display("FAIL reset_out got out=%b cause=%0d exp out=0 cause=0", ir_out, ir_cause);
        end
        n_vec++;
        if (pending !== 4'b0000 || overflow !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got pend=%b ovf=%b exp 0000/0000", pending, overflow);
        end
    endtask

    task automatic test_single();
        apply_reset();
        irq_mask = 4'hF;
        irq_src  = 4'b0100;
        tick(); tick();
        n_vec++;
        if (pending !== 4'b0000) begin
            n_err++; $display("FAIL single_early got pend=%b exp 0000", pending);
        end
        tick();
        n_vec++;
        if (pending !== 4'b0100 || ir_out !== 1'b0) begin
            n_err++; $display("FAIL single_pend got pend=%b out=%b exp 0100/0", pending, ir_out);
        end
        tick();
        n_vec++;
        if (ir_out !== 1'b1 || ir_cause !== 2'd2) begin
            n_err++; $display("FAIL single_req got out=%b cause=%0d exp 1/2", ir_out, ir_cause);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        n_vec++;
        if (ir_out !== 1'b0 || pending !== 4'b0000 || ir_cause !== 2'd2) begin
            n_err++; $display("FAIL single_ack got out=%b pend=%b cause=%0d exp 0/0000/2", ir_out, pending, ir_cause);
        end
        ir_eret = 1'b1; tick(); ir_eret = 1'b0;
        tick();
        n_vec++;
        if (ir_out !== 1'b0) begin
            n_err++; $display("FAIL single_idle got out=%b exp 0", ir_out);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        irq_mask = 4'hF;
        irq_src  = 4'b1010;
        tick(); tick(); tick(); tick();
        n_vec++;
        if (ir_out !== 1'b1 || ir_cause !== 2'd1 || pending !== 4'b1010) begin
            n_err++; $display("FAIL prio_first got out=%b cause=%0d pend=%b exp 1/1/1010", ir_out, ir_cause, pending);
        end
        irq_src = 4'b0000;
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        ir_eret = 1'b1; tick(); ir_eret = 1'b0;
        n_vec++;
        if (ir_out !== 1'b0 || pending !== 4'b1000) begin
            n_err++; $display("FAIL prio_gap got out=%b pend=%b exp 0/1000", ir_out, pending);
        end
        tick();
        n_vec++;
        if (ir_out !== 1'b1 || ir_cause !== 2'd3) begin
            n_err++; $display("FAIL prio_second got out=%b cause=%0d exp 1/3", ir_out, ir_cause);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        irq_mask = 4'hF;
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000; tick();
        irq_src = 4'b0001; tick();
        irq_src = 4'b0000;
        tick(); tick(); tick();
        n_vec++;
        if (overflow !== 4'b0001 || pending[0] !== 1'b1) begin
            n_err++; $display("FAIL ovf_set got ovf=%b pend0=%b exp 0001/1", overflow, pending[0]);
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++;
        if (overflow !== 4'b0000 || pending[0] !== 1'b1) begin
            n_err++; $display("FAIL ovf_clr got ovf=%b pend0=%b exp 0000/1", overflow, pending[0]);
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        irq_mask = 4'hF;
        irq_src  = 4'b0010;
        tick(); tick(); tick(); tick();
        irq_mask = 4'b1101;
        tick();
        n_vec++;
        if (ir_out !== 1'b0 || pending[1] !== 1'b1) begin
            n_err++; $display("FAIL withdraw got out=%b pend1=%b exp 0/1", ir_out, pending[1]);
        end
        tick();
        irq_mask = 4'hF;
        tick();
        n_vec++;
        if (ir_out !== 1'b1 || ir_cause !== 2'd1) begin
            n_err++; $display("FAIL withdraw_again got out=%b cause=%0d exp 1/1", ir_out, ir_cause);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        irq_mask = 4'hF;
        irq_src  = 4'b0100;
        tick(); tick(); tick(); tick();
        irq_src = 4'b0000;
        tick(); tick(); tick();
        irq_src = 4'b0100;
        tick(); tick();
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        n_vec++;
        if (ir_out !== 1'b0 || pending[2] !== 1'b1 || overflow !== 4'b0000) begin
            n_err++; $display("FAIL collision got out=%b pend2=%b ovf=%b exp 0/1/0000", ir_out, pending[2], overflow);
        end
    endtask

    task automatic test_reset_mid_service();
        apply_reset();
        irq_mask = 4'hF;
        irq_src  = 4'b1011;
        tick(); tick(); tick(); tick();
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        n_vec++;
        if (pending !== 4'b1010) begin
            n_err++; $display("FAIL rms_pend got pend=%b exp 1010", pending);
        end
        irq_src = 4'b1000;
        rst = 1'b1; tick();
        n_vec++;
        if (ir_out !== 1'b0 || ir_cause !== 2'd0 || pending !== 4'b0000 || overflow !== 4'b0000) begin
            n_err++; $display("FAIL rms_reset got out=%b cause=%0d pend=%b ovf=%b exp all 0", ir_out, ir_cause, pending, overflow);
        end
        rst = 1'b0;
        tick(); tick();
        n_vec++;
        if (pending !== 4'b0000) begin
            n_err++; $display("FAIL rms_early got pend=%b exp 0000", pending);
        end
        tick();
        n_vec++;
        if (pending !== 4'b1000) begin
            n_err++; $display("FAIL rms_held got pend=%b exp 1000", pending);
        end
    endtask

    task automatic test_random();
        apply_reset();
        irq_mask = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
            end
            if ($urandom_range(15) == 0) irq_mask = N'($urandom);
            ir_ack  = ($urandom_range(3) == 0);
            ir_eret = ($urandom_range(3) == 0);
            ovf_clr = ($urandom_range(15) == 0);
            rst     = ($urandom_range(249) == 0);
            tick();
            n_vec++;
            if (ir_out !== m_out || ir_cause !== CW'(m_cause)) begin
                n_err++; $display("FAIL rand_req cyc %0d got out=%b cause=%0d exp %b/%0d", c, ir_out, ir_cause, m_out, m_cause);
            end
            n_vec++;
            if (pending !== m_pend || overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_flags cyc %0d got pend=%b ovf=%b exp %b/%b", c, pending, overflow, m_pend, m_ovf);
            end
        end
        rst = 1'b0; ir_ack = 1'b0; ir_eret = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_single();
        test_priority();
        test_overflow();
        test_withdraw();
        test_collision();
        test_reset_mid_service();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
